// File: rtl/ex_lsu.sv
// rtl/ex_lsu.sv - execute-stage load/store unit: one data-bus transaction per load/store
// with pipeline stall, misalignment detection, bus timeout and load formatting.
module ex_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_load_access_id_ex,
    input  logic        ram_store_access_id_ex,
    input  logic [31:0] ram_load_addr_id_ex,
    input  logic [31:0] ram_store_addr_id_ex,
    input  logic [31:0] ram_store_data_id_ex,
    input  logic [31:0] instruction_id_ex,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall_n,
    output logic        misaligned_load,
    output logic        misaligned_store,
    output logic        access_fault
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      lat_off;
    logic [1:0]      lat_width;
    logic            lat_uns;

    logic            active;
    logic            is_store;
    logic [31:0]     addr;
    logic [1:0]      width;
    logic            misaligned;
    logic [3:0]      be_next;
    logic [31:0]     wdata_next;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [31:0]     ld_fmt;
    logic            unused;

    assign unused   = ^{instruction_id_ex[31:15], instruction_id_ex[11:0]};
    assign is_store = ram_store_access_id_ex;
    assign active   = ram_load_access_id_ex | ram_store_access_id_ex;
    assign addr     = is_store ? ram_store_addr_id_ex : ram_load_addr_id_ex;
    assign width    = instruction_id_ex[13:12];

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = ram_store_data_id_ex;
        case (width)
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{ram_store_data_id_ex[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ram_store_data_id_ex[15:0]}};
            end
            default: misaligned = |addr[1:0];
        endcase
    end

    // Load formatting works on the raw bus word using the lane info latched at issue.
    always_comb begin
        rbyte  = bus_rdata[{lat_off, 3'b000} +: 8];
        rhalf  = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_fmt = bus_rdata;
        case (lat_width)
            2'b00:   ld_fmt = lat_uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   ld_fmt = lat_uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Reset releases the pipeline even if the ID/EX inputs still show an access.
    assign stall_n = !rst_n ? 1'b1
                   : !((state == IDLE && active && !misaligned) || state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            lat_off          <= 2'b00;
            lat_width        <= 2'b00;
            lat_uns          <= 1'b0;
            bus_req          <= 1'b0;
            bus_we           <= 1'b0;
            bus_addr         <= 32'h0;
            bus_be           <= 4'h0;
            bus_wdata        <= 32'h0;
            load_data        <= 32'h0;
            load_valid       <= 1'b0;
            misaligned_load  <= 1'b0;
            misaligned_store <= 1'b0;
            access_fault     <= 1'b0;
        end else begin
            load_valid       <= 1'b0;
            misaligned_load  <= 1'b0;
            misaligned_store <= 1'b0;
            access_fault     <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        if (misaligned) begin
                            misaligned_store <= is_store;
                            misaligned_load  <= !is_store;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            lat_off   <= addr[1:0];
                            lat_width <= width;
                            lat_uns   <= instruction_id_ex[14];
                            wait_cnt  <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (!bus_we) begin
                            load_data  <= ld_fmt;
                            load_valid <= 1'b1;
                        end
                    end else if (TIMEOUT > 0 && 32'(wait_cnt) == TIMEOUT - 1) begin
                        bus_req      <= 1'b0;
                        access_fault <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_lsu.sv
// tb/tb_ex_lsu.sv - scoreboard bench for ex_lsu: directed test-plan cases, mid-REQ reset,
// then randomized loads/stores checked against a byte-level reference model.
module tb_ex_lsu;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_load_access_id_ex = 1'b0;
    logic        ram_store_access_id_ex = 1'b0;
    logic [31:0] ram_load_addr_id_ex = 32'h0;
    logic [31:0] ram_store_addr_id_ex = 32'h0;
    logic [31:0] ram_store_data_id_ex = 32'h0;
    logic [31:0] instruction_id_ex = 32'h0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        load_valid, stall_n, misaligned_load, misaligned_store, access_fault;

    ex_lsu #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ram_load_access_id_ex(ram_load_access_id_ex),
        .ram_store_access_id_ex(ram_store_access_id_ex),
        .ram_load_addr_id_ex(ram_load_addr_id_ex),
        .ram_store_addr_id_ex(ram_store_addr_id_ex),
        .ram_store_data_id_ex(ram_store_data_id_ex),
        .instruction_id_ex(instruction_id_ex),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .load_data(load_data), .load_valid(load_valid), .stall_n(stall_n),
        .misaligned_load(misaligned_load), .misaligned_store(misaligned_store),
        .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BUS, EV_STALL, EV_LOAD, EV_FAULT, EV_MISL, EV_MISS} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] v;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
    } ev_t;

    ev_t         expq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cur_wait = 0;
    logic [31:0] cur_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void push(input ev_kind_t k, input logic [31:0] v, input logic [31:0] wd,
                                 input logic [3:0] be, input logic we);
        ev_t e;
        e.kind = k; e.v = v; e.wd = wd; e.be = be; e.we = we;
        expq.push_back(e);
    endfunction

    task automatic pop_check(input ev_kind_t k, input logic [31:0] v, input logic [31:0] wd,
                             input logic [3:0] be, input logic we);
        ev_t e;
        if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected event: got kind %0d expected none", k);
        end else begin
            e = expq.pop_front();
            chk("event kind", 32'(k), 32'(e.kind));
            if (k == e.kind) begin
                case (k)
                    EV_BUS: begin
                        chk("bus_addr", v, e.v);
                        chk("bus_be", {28'b0, be}, {28'b0, e.be});
                        chk("bus_we", {31'b0, we}, {31'b0, e.we});
                        if (e.we) chk("bus_wdata", wd, e.wd);
                    end
                    EV_STALL: chk("stall length", v, e.v);
                    EV_LOAD:  chk("load_data", v, e.v);
                    default: ;
                endcase
            end
        end
    endtask

    // Monitor: samples just before each rising edge and matches DUT events in order.
    initial begin
        logic prev_req;
        int   run;
        prev_req = 1'b0;
        run = 0;
        forever begin
            @(posedge clk);
            #8;
            if (!rst_n) begin
                prev_req = 1'b0;
                run = 0;
            end else begin
                if (bus_req && !prev_req) pop_check(EV_BUS, bus_addr, bus_wdata, bus_be, bus_we);
                if (!stall_n) run++;
                else if (run > 0) begin
                    pop_check(EV_STALL, 32'(run), 32'h0, 4'h0, 1'b0);
                    run = 0;
                end
                if (load_valid)       pop_check(EV_LOAD, load_data, 32'h0, 4'h0, 1'b0);
                if (access_fault)     pop_check(EV_FAULT, 32'h0, 32'h0, 4'h0, 1'b0);
                if (misaligned_load)  pop_check(EV_MISL, 32'h0, 32'h0, 4'h0, 1'b0);
                if (misaligned_store) pop_check(EV_MISS, 32'h0, 32'h0, 4'h0, 1'b0);
                prev_req = bus_req;
            end
        end
    end

    // Bus responder: ready after cur_wait REQ cycles; random ready noise while idle.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) begin
                if (n == cur_wait) begin
                    bus_ready = 1'b1;
                    bus_rdata = cur_rdata;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                end
                n++;
            end else begin
                n = 0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
    end

    // Presents one ID/EX instruction (called at posedge+3) and holds it until the pipeline advances.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] la, input logic [31:0] sa, input logic [31:0] sd,
                         input int wt, input logic [31:0] rd);
        logic [31:0] a, wd, mask, lv;
        logic [3:0]  be;
        int          sz, nreq, steps;
        logic        s;
        a  = st ? sa : la;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (ld || st) begin
            if (a % sz != 0) begin
                push(st ? EV_MISS : EV_MISL, 32'h0, 32'h0, 4'h0, 1'b0);
            end else begin
                be = 4'(((1 << sz) - 1) << (a % 4));
                wd = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
                push(EV_BUS, a & ~32'h3, wd, be, st);
                nreq = (wt < T) ? wt + 1 : T;
                push(EV_STALL, 32'(1 + nreq), 32'h0, 4'h0, 1'b0);
                if (wt >= T) push(EV_FAULT, 32'h0, 32'h0, 4'h0, 1'b0);
                else if (!st) begin
                    mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
                    lv   = (rd >> (8 * (a % 4))) & mask;
                    if (!f3[2] && sz < 4 && lv[8 * sz - 1]) lv = lv | ~mask;
                    push(EV_LOAD, lv, 32'h0, 4'h0, 1'b0);
                end
            end
        end
        cur_wait  = wt;
        cur_rdata = rd;
        ram_load_access_id_ex  = ld;
        ram_store_access_id_ex = st;
        ram_load_addr_id_ex    = la;
        ram_store_addr_id_ex   = sa;
        ram_store_data_id_ex   = sd;
        instruction_id_ex      = $urandom;
        instruction_id_ex[14:12] = f3;
        steps = 0;
        forever begin
            #4;
            s = stall_n;
            @(posedge clk);
            #3;
            steps++;
            if (s) break;
            if (steps > 40) begin
                chk("pipeline advance", 32'(steps), 32'd0);
                break;
            end
        end
        ram_load_access_id_ex  = 1'b0;
        ram_store_access_id_ex = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, wt;
        logic [2:0]  f3;
        logic [31:0] la, sa;
        #2;
        chk("reset bus_req", {31'b0, bus_req}, 32'd0);
        chk("reset bus_be", {28'b0, bus_be}, 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset pulses", {27'b0, load_valid, misaligned_load, misaligned_store, access_fault, bus_we}, 32'd0);
        chk("reset stall_n", {31'b0, stall_n}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        issue(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 32'h8765_4321);
        issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 1, 32'h8012_3456);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 32'h0, 0, 32'h8012_3456);
        issue(0, 1, 3'b001, 32'h0, 32'h102, 32'h1234_ABCD, 3, 32'h0);
        issue(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 32'h0);
        issue(0, 1, 3'b001, 32'h0, 32'h101, 32'h5555_AAAA, 0, 32'h0);
        issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        issue(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 9, 32'h0);
        issue(1, 1, 3'b000, 32'h111, 32'h122, 32'hCAFE_F00D, 2, 32'h0);
        issue(1, 0, 3'b001, 32'h10E, 32'h0, 32'h0, 3, 32'hBEEF_0123);

        // Reset in the second REQ cycle of an outstanding load.
        push(EV_BUS, 32'h200, 32'h0, 4'hF, 1'b0);
        cur_wait = 50;
        ram_load_access_id_ex = 1'b1;
        ram_load_addr_id_ex   = 32'h200;
        instruction_id_ex     = 32'h0000_2003;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset mid-REQ bus_req", {31'b0, bus_req}, 32'd0);
        chk("reset mid-REQ stall_n", {31'b0, stall_n}, 32'd1);
        ram_load_access_id_ex = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        issue(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 32'h1357_9BDF);

        for (int i = 0; i < 250; i++) begin
            k  = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            la = 32'h100 + 32'($urandom_range(0, 63));
            sa = 32'h180 + 32'($urandom_range(0, 63));
            wt = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            issue(k >= 2 && k <= 5 || k == 9, k >= 6, f3, la, sa, $urandom, wt, $urandom);
        end

        repeat (4) @(posedge clk);
        #9;
        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
